// File: rtl/led_rf_div_pkg.sv
// Shared constants and helpers for the LED/RF divider bank.
// Channel addressing: LED channels first, then RF carrier, then key pattern.
package led_rf_div_pkg;

    localparam int CH_RF_OFS  = 0;
    localparam int CH_KEY_OFS = 1;
    localparam int CW_DEFAULT = 25;

    function automatic int chw(input int n);
        return $clog2(n + 2);
    endfunction

    function automatic int unsigned div_default(input int cw);
        return (2 ** (cw - 1)) - 1;
    endfunction

    localparam int unsigned DIV_DEFAULT = div_default(CW_DEFAULT);

endpackage

// File: rtl/led_rf_divider_bank_if.sv
// Configuration port and divider outputs of led_rf_divider_bank.
// The controller side uses master; the divider bank uses slave.
interface led_rf_divider_bank_if
    import led_rf_div_pkg::*;
#(
    parameter int NCH = 3,
    parameter int CW  = CW_DEFAULT
) ();

    localparam int CHW = chw(NCH);

    logic           cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic           cfg_busy;
    logic           cfg_err;
    logic [NCH-1:0] div_out;
    logic           rf;

    modport master (
        output cfg_we, cfg_ch, cfg_div,
        input  cfg_busy, cfg_err, div_out, rf
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_div,
        output cfg_busy, cfg_err, div_out, rf
    );

endinterface

// File: rtl/div_channel.sv
// One programmable divider: counts 0..div, toggles q on wrap.
// New divisors wait in a shadow register until the current period ends.
module div_channel #(
    parameter int            CW      = 25,
    parameter logic [CW-1:0] DIV_RST = {1'b0, {(CW-1){1'b1}}}
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [CW-1:0] wr_data,
    output logic          busy,
    output logic          wrap,
    output logic          q
);

    logic [CW-1:0] cnt;
    logic [CW-1:0] div;
    logic [CW-1:0] shadow;
    logic          pending;
    logic          q_r;

    assign wrap = (cnt == div);
    assign busy = pending;
    assign q    = q_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            div     <= DIV_RST;
            shadow  <= DIV_RST;
            pending <= 1'b0;
            q_r     <= 1'b0;
        end else begin
            if (wrap) begin
                cnt <= '0;
                q_r <= ~q_r;
                if (pending) begin
                    div     <= shadow;
                    pending <= 1'b0;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
            // A write landing on a wrap only arms the shadow; it applies one period later.
            if (wr && !pending) begin
                shadow  <= wr_data;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_rf_divider_bank.sv
// NCH LED divider channels plus one RF carrier channel with a registered rf output.
// Optional on-off keying of rf is built when RF_KEY_EN is defined.
module led_rf_divider_bank
    import led_rf_div_pkg::*;
#(
    parameter int          NCH     = 3,
    parameter int          CW      = CW_DEFAULT,
    parameter int unsigned DIV_RST = div_default(CW)
`ifdef RF_KEY_EN
    ,
    parameter int                  KEY_BITS = 16,
    parameter int                  SYM_LEN  = 1000000,
    parameter logic [KEY_BITS-1:0] KEY_RST  = '1
`endif
) (
    input logic                  CLK1,
    input logic                  RST,
    led_rf_divider_bank_if.slave bus
);

    localparam int CHW   = chw(NCH);
    localparam int RF_CH = NCH + CH_RF_OFS;

    logic [NCH:0] ch_wr;
    logic [NCH:0] ch_busy;
    logic [NCH:0] ch_wrap;
    logic [NCH:0] ch_q;
    logic         sel_busy;
    logic         key_wr;
    logic         gate;
    logic         err_q;
    logic         rf_q;

    // Address decode: a divider write is accepted only when its channel is idle.
    always_comb begin
        ch_wr    = '0;
        sel_busy = 1'b0;
        for (int i = 0; i <= NCH; i++) begin
            if (bus.cfg_ch == CHW'(i)) begin
                sel_busy = ch_busy[i];
                ch_wr[i] = bus.cfg_we && !ch_busy[i];
            end
        end
    end

    for (genvar g = 0; g <= NCH; g++) begin : g_ch
        div_channel #(
            .CW      (CW),
            .DIV_RST (CW'(DIV_RST))
        ) u_ch (
            .clk     (CLK1),
            .rst     (RST),
            .wr      (ch_wr[g]),
            .wr_data (bus.cfg_div),
            .busy    (ch_busy[g]),
            .wrap    (ch_wrap[g]),
            .q       (ch_q[g])
        );
    end

`ifdef RF_KEY_EN
    localparam int KEY_CH = NCH + CH_KEY_OFS;
    localparam int SCW    = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;

    logic [SCW-1:0]         sym_cnt;
    logic [KEY_BITS-1:0]    pattern;
    logic [KEY_BITS-1:0]    key_wdata;
    logic [KEY_BITS+CW-1:0] key_ext;
    logic                   key_bit;

    assign key_wr    = bus.cfg_we && (bus.cfg_ch == CHW'(KEY_CH));
    assign key_ext   = {{KEY_BITS{1'b0}}, bus.cfg_div};
    assign key_wdata = key_ext[KEY_BITS-1:0];
    assign gate      = key_bit;

    // Pattern writes restart the symbol immediately rather than waiting for a boundary.
    always_ff @(posedge CLK1 or posedge RST) begin
        if (RST) begin
            sym_cnt <= '0;
            pattern <= KEY_RST;
            key_bit <= KEY_RST[KEY_BITS-1];
        end else if (key_wr) begin
            sym_cnt <= '0;
            pattern <= key_wdata;
            key_bit <= key_wdata[KEY_BITS-1];
        end else if (sym_cnt == SCW'(SYM_LEN - 1)) begin
            sym_cnt <= '0;
            pattern <= {pattern[KEY_BITS-2:0], pattern[KEY_BITS-1]};
            key_bit <= pattern[KEY_BITS-2];
        end else begin
            sym_cnt <= sym_cnt + SCW'(1);
        end
    end
`else
    assign key_wr = 1'b0;
    assign gate   = 1'b1;
`endif

    always_ff @(posedge CLK1 or posedge RST) begin
        if (RST) begin
            err_q <= 1'b0;
        end else if (bus.cfg_we && (ch_wr == '0) && !key_wr) begin
            err_q <= 1'b1;
        end
    end

    always_ff @(posedge CLK1 or posedge RST) begin
        if (RST) begin
            rf_q <= 1'b0;
        end else begin
            rf_q <= ch_q[RF_CH] & gate;
        end
    end

    assign bus.cfg_busy = sel_busy;
    assign bus.cfg_err  = err_q;
    assign bus.div_out  = ch_q[NCH-1:0];
    assign bus.rf       = rf_q;

endmodule
